// File: rtl/alu_pipe.sv
// ---------------------------------------------------------------------------
// alu_pipe
//
// Purpose:
//   Pipelined ALU with a valid/ready handshake on both sides. Single-cycle
//   operations (add, sub, logic, compare, set-less-than, shifts) produce a
//   registered result on the acceptance edge. Multiply is an iterative
//   shift-add sequence that takes WIDTH cycles. During that time the input
//   side is held off.
//
// Parameters:
//   WIDTH  operand / result width (power of 2, 8..64)
//   SHW    shift-amount width, taken from the low bits of inp_2
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   operation offered
//   in_ready   operation can be accepted this cycle
//   inp_1      operand A
//   inp_2      operand B / shift amount (low SHW bits)
//   alu_op     4-bit operation code
//   out_valid  result and flags are valid
//   out_ready  consumer takes the result this cycle
//   result     registered result
//   zero       result is zero (for cmp-eq: operands are equal)
//   carry      add carry-out / sub borrow
//   overflow   signed overflow for add/sub
//   err        illegal opcode
// ---------------------------------------------------------------------------
module alu_pipe #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] inp_1,
    input  logic [WIDTH-1:0] inp_2,
    input  logic [3:0]       alu_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry,
    output logic             overflow,
    output logic             err
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_SUB  = 4'b0010;
    localparam logic [3:0] OP_AND  = 4'b0011;
    localparam logic [3:0] OP_OR   = 4'b0100;
    localparam logic [3:0] OP_XOR  = 4'b0101;
    localparam logic [3:0] OP_CMPE = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_SLTU = 4'b1000;
    localparam logic [3:0] OP_SLL  = 4'b1001;
    localparam logic [3:0] OP_SRL  = 4'b1010;
    localparam logic [3:0] OP_SRA  = 4'b1011;
    localparam logic [3:0] OP_MUL  = 4'b1100;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_t;

    state_t state;
    state_t state_next;

    logic             accept;
    logic             accept_mul;
    logic             accept_single;

    // Multiplier working registers.
    logic [WIDTH-1:0] mul_mcand;
    logic [WIDTH-1:0] mul_mplier;
    logic [WIDTH-1:0] mul_acc;
    logic [WIDTH-1:0] mul_acc_next;
    logic [CW-1:0]    mul_cnt;
    logic             mul_last;

    // Single-cycle datapath outputs.
    logic [WIDTH:0]   sum_ext;
    logic [WIDTH-1:0] diff;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] alu_res;
    logic             alu_zero;
    logic             alu_carry;
    logic             alu_ovf;
    logic             alu_err;
    logic             alu_is_cmp;

    // A new operation is accepted only when idle and the output register is
    // either empty or being drained on this same edge.
    assign in_ready      = (state == IDLE) && (!out_valid || out_ready);
    assign accept        = in_valid && in_ready;
    assign accept_mul    = accept && (alu_op == OP_MUL);
    assign accept_single = accept && (alu_op != OP_MUL);

    // The WIDTH-th iteration is the one whose count reads WIDTH-1. Its
    // accumulated value goes straight into the output register.
    assign mul_last     = (state == MUL) && (mul_cnt == CW'(WIDTH - 1));
    assign mul_acc_next = mul_mplier[0] ? (mul_acc + mul_mcand) : mul_acc;

    assign sum_ext = {1'b0, inp_1} + {1'b0, inp_2};
    assign diff    = inp_1 - inp_2;
    assign shamt   = inp_2[SHW-1:0];

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next state. A multiply leaves IDLE on acceptance and returns once
    // the last iteration has been folded into the result.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept_mul) begin
                    state_next = MUL;
                end
            end
            MUL: begin
                if (mul_last) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Single-cycle operations. Borrow for sub is the unsigned A<B compare.
    // Signed overflow happens when the result sign disagrees with what the
    // operand signs allow.
    always_comb begin
        alu_res    = '0;
        alu_carry  = 1'b0;
        alu_ovf    = 1'b0;
        alu_err    = 1'b0;
        alu_is_cmp = 1'b0;
        case (alu_op)
            OP_ADD: begin
                alu_res   = sum_ext[WIDTH-1:0];
                alu_carry = sum_ext[WIDTH];
                alu_ovf   = (inp_1[WIDTH-1] == inp_2[WIDTH-1]) &&
                            (sum_ext[WIDTH-1] != inp_1[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res   = diff;
                alu_carry = (inp_1 < inp_2);
                alu_ovf   = (inp_1[WIDTH-1] != inp_2[WIDTH-1]) &&
                            (diff[WIDTH-1] != inp_1[WIDTH-1]);
            end
            OP_AND:  alu_res = inp_1 & inp_2;
            OP_OR:   alu_res = inp_1 | inp_2;
            OP_XOR:  alu_res = inp_1 ^ inp_2;
            OP_CMPE: alu_is_cmp = 1'b1;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(inp_1) < $signed(inp_2))};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (inp_1 < inp_2)};
            OP_SLL:  alu_res = inp_1 << shamt;
            OP_SRL:  alu_res = inp_1 >> shamt;
            OP_SRA:  alu_res = WIDTH'($signed(inp_1) >>> shamt);
            OP_MUL:  alu_res = '0;
            default: alu_err = 1'b1;
        endcase

        // Zero follows the result, except that cmp-eq reports equality and
        // illegal opcodes never raise it.
        if (alu_err) begin
            alu_zero = 1'b0;
        end else if (alu_is_cmp) begin
            alu_zero = (inp_1 == inp_2);
        end else begin
            alu_zero = (alu_res == '0);
        end
    end

    // Multiplier sequencing. Operands are captured on acceptance. After that,
    // each cycle adds the shifted multiplicand when the current multiplier
    // bit is set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mul_mcand  <= '0;
            mul_mplier <= '0;
            mul_acc    <= '0;
            mul_cnt    <= '0;
        end else if (accept_mul) begin
            mul_mcand  <= inp_1;
            mul_mplier <= inp_2;
            mul_acc    <= '0;
            mul_cnt    <= '0;
        end else if (state == MUL) begin
            mul_mcand  <= mul_mcand << 1;
            mul_mplier <= mul_mplier >> 1;
            mul_acc    <= mul_acc_next;
            mul_cnt    <= mul_cnt + CW'(1);
        end
    end

    // Output register. A new result takes priority over a drain, so a
    // transfer and an acceptance on the same edge keep out_valid high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
            carry     <= 1'b0;
            overflow  <= 1'b0;
            err       <= 1'b0;
        end else if (accept_single) begin
            out_valid <= 1'b1;
            result    <= alu_res;
            zero      <= alu_zero;
            carry     <= alu_carry;
            overflow  <= alu_ovf;
            err       <= alu_err;
        end else if (mul_last) begin
            out_valid <= 1'b1;
            result    <= mul_acc_next;
            zero      <= (mul_acc_next == '0);
            carry     <= 1'b0;
            overflow  <= 1'b0;
            err       <= 1'b0;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
